// File: rtl/mux7seg_pkg.sv
// mux7seg_pkg: shared constants and types for the multiplexed 7-segment scanner.
//   SEG_TABLE   : hex 0..F to active-low segments, bit 6 = a ... bit 0 = g
//   SEG_OFF     : all segments dark
//   digit_sel_t : attributes of the digit currently being scanned
package mux7seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Lowercase glyphs for b and d so they cannot be confused with 8 and 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
    7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
    7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
    7'h31, 7'h42, 7'h30, 7'h38    // C d E F
  };

  typedef struct packed {
    logic [3:0] val;
    logic       dp_req;
    logic       dark;
  } digit_sel_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    return SEG_TABLE[v];
  endfunction

endpackage

// File: rtl/mux7seg_prescale.sv
// mux7seg_prescale: scan timing for the display.
//   clk, clr_n     : clock, async active-low reset
//   o_slot_cnt     : position within the current digit slot, 0..DIV-1
//   o_idx          : digit being scanned, 0..NDIG-1
//   o_frame_tick   : high in the last cycle of the last slot of a frame
//   o_blink_phase  : toggles every BLINK_FRAMES frames
module mux7seg_prescale
  import mux7seg_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 32,
  parameter int SLOT_W       = $clog2(DIV),
  parameter int IDX_W        = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              clr_n,
  output logic [SLOT_W-1:0] o_slot_cnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_frame_tick,
  output logic              o_blink_phase
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0] r_slot_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink_phase;
  logic              w_tick;
  logic              w_frame_tick;
  logic              w_blink_wrap;

  assign w_tick       = (r_slot_cnt == SLOT_W'(DIV - 1));
  assign w_frame_tick = w_tick && (r_idx == IDX_W'(NDIG - 1));
  assign w_blink_wrap = (r_frame_cnt == FC_W'(BLINK_FRAMES - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_slot_cnt <= w_tick ? '0 : r_slot_cnt + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      if (w_frame_tick) begin
        if (w_blink_wrap) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign o_slot_cnt    = r_slot_cnt;
  assign o_idx         = r_idx;
  assign o_frame_tick  = w_frame_tick;
  assign o_blink_phase = r_blink_phase;

endmodule

// File: rtl/mux7seg_scan.sv
// mux7seg_scan: time-multiplexed 7-segment driver with guard band, PWM
// brightness, blinking, blanking and leading-zero suppression.
//   clk, clr_n  : clock, async active-low reset
//   x           : 4 bits per digit, digit 0 rightmost
//   dp_in       : decimal point request per digit
//   blank       : force digit dark
//   blink_mask  : digit blinks
//   lz_en       : leading-zero suppression
//   bright      : PWM duty, (bright+1)/16
//   an          : anode enables, active-low
//   a2g, dp     : segments a..g and decimal point, active-low
//   frame_start : one-cycle pulse when the new snapshot becomes visible
module mux7seg_scan
  import mux7seg_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [4*NDIG-1:0] x,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank,
  input  logic [NDIG-1:0]   blink_mask,
  input  logic              lz_en,
  input  logic [3:0]        bright,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        a2g,
  output logic              dp,
  output logic              frame_start
);

  localparam int SLOT_W = $clog2(DIV);
  localparam int IDX_W  = $clog2(NDIG);

  logic [SLOT_W-1:0] w_slot_cnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_frame_tick;
  logic              w_blink_phase;

  logic [3:0]        r_pwm_cnt;
  logic [4*NDIG-1:0] r_snap_x;
  logic [NDIG-1:0]   r_snap_dp;
  logic [NDIG-1:0]   r_snap_blank;
  logic [NDIG-1:0]   r_snap_blink;
  logic              r_snap_lz;

  logic [NDIG-1:0]   w_supp;
  logic              w_all_zero;
  digit_sel_t        w_sel;
  logic              w_guard_ok;
  logic              w_lit;

  mux7seg_prescale #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .SLOT_W       (SLOT_W),
    .IDX_W        (IDX_W)
  ) u_prescale (
    .clk           (clk),
    .clr_n         (clr_n),
    .o_slot_cnt    (w_slot_cnt),
    .o_idx         (w_idx),
    .o_frame_tick  (w_frame_tick),
    .o_blink_phase (w_blink_phase)
  );

  // Inputs are only sampled at the frame boundary so a frame never mixes values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pwm_cnt    <= '0;
      r_snap_x     <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= '0;
      r_snap_blink <= '0;
      r_snap_lz    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_frame_tick) begin
        r_snap_x     <= x;
        r_snap_dp    <= dp_in;
        r_snap_blank <= blank;
        r_snap_blink <= blink_mask;
        r_snap_lz    <= lz_en;
      end
    end
  end

  // Walk from the most significant digit down; a digit is suppressed while
  // everything from it upward is zero. Digit 0 always shows.
  always_comb begin
    w_all_zero = 1'b1;
    w_supp     = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_all_zero = w_all_zero & (r_snap_x[4*i +: 4] == 4'h0);
      if (i != 0)
        w_supp[i] = r_snap_lz & w_all_zero;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (IDX_W'(i) == w_idx) begin
        w_sel.val    = r_snap_x[4*i +: 4];
        w_sel.dp_req = r_snap_dp[i];
        w_sel.dark   = r_snap_blank[i] | (w_blink_phase & r_snap_blink[i]) | w_supp[i];
      end
    end
  end

  // Anodes stay off for the first GUARD cycles of a slot to hide ghosting.
  if (GUARD == 0) begin : g_no_guard
    assign w_guard_ok = 1'b1;
  end else begin : g_guard
    assign w_guard_ok = (w_slot_cnt >= SLOT_W'(GUARD));
  end

  assign w_lit = w_guard_ok && (r_pwm_cnt <= bright) && !w_sel.dark;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an          <= '1;
      a2g         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_frame_tick;
      if (w_lit) begin
        an  <= ~(NDIG'(1) << w_idx);
        a2g <= hex_to_seg(w_sel.val);
        dp  <= ~w_sel.dp_req;
      end else begin
        an  <= '1;
        a2g <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux7seg_scan.sv
module tb_mux7seg_scan;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 1;
  localparam int BF    = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic [15:0] x = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  bright = '0;
  logic [3:0]  an;
  logic [6:0]  a2g;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  // edges since reset release, and the model's copy of the frame snapshot
  int          n = 0;
  logic [15:0] s_x = '0;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_blank = '0;
  logic [3:0]  s_blink = '0;
  logic        s_lz = 1'b0;

  // lit segments of each hex glyph, by letter
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  mux7seg_scan #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .x           (x),
    .dp_in       (dp_in),
    .blank       (blank),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .bright      (bright),
    .an          (an),
    .a2g         (a2g),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_seg(int v);
    logic [6:0] r;
    string s;
    r = 7'h7F;
    s = glyph[v];
    for (int k = 0; k < s.len(); k++)
      r[6 - (int'(s[k]) - 97)] = 1'b0;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_a2g"}, 32'(a2g), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // One clock: predict what the coming edge produces from the scan position
  // and snapshot in effect now, then compare after the edge.
  task automatic step();
    int   slot, d, frame, phase, pwm, dig;
    bit   supp, lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    slot  = n % DIV;
    d     = (n / DIV) % NDIG;
    frame = n / FRAME;
    phase = (frame / BF) % 2;
    pwm   = n % 16;
    dig   = int'((s_x >> (4 * d)) & 16'hF);
    supp  = 1'b0;
    if (s_lz && d > 0) begin
      supp = 1'b1;
      for (int j = d; j < NDIG; j++)
        if (((s_x >> (4 * j)) & 16'hF) != 0) supp = 1'b0;
    end
    lit = (slot >= GUARD) && (pwm <= int'(bright)) && !s_blank[d] &&
          !(phase == 1 && s_blink[d]) && !supp;
    e_an  = lit ? ~(4'b0001 << d) : 4'hF;
    e_seg = lit ? glyph_seg(dig) : 7'h7F;
    e_dp  = lit ? ~s_dp[d] : 1'b1;
    e_fs  = ((n % FRAME) == FRAME - 1);
    if (e_fs) begin
      s_x = x; s_dp = dp_in; s_blank = blank; s_blink = blink_mask; s_lz = lz_en;
    end
    @(posedge clk);
    n++;
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("a2g", 32'(a2g), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
  endtask

  task automatic run(int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic rnd_inputs();
    x          = 16'($urandom);
    dp_in      = 4'($urandom);
    blank      = 4'($urandom & $urandom);
    blink_mask = 4'($urandom);
    lz_en      = 1'($urandom);
    bright     = 4'($urandom);
  endtask

  task automatic model_reset();
    n = 0;
    s_x = '0; s_dp = '0; s_blank = '0; s_blink = '0; s_lz = 1'b0;
  endtask

  initial begin
    // power-on reset
    #2 clr_n = 1'b0;
    #1 chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst1");
    clr_n = 1'b1;
    model_reset();

    // scan order and guard band; first frame shows the all-zero snapshot
    x = 16'h1234; bright = 4'd15; dp_in = 4'b0100;
    run(3 * FRAME);

    // leading-zero suppression, dp request on a suppressed digit stays dark
    x = 16'h0050; lz_en = 1'b1; dp_in = 4'b1000;
    run(3 * FRAME);

    // mid-frame input change only shows from the next frame
    lz_en = 1'b0; dp_in = 4'b0000; x = 16'h1111;
    run(FRAME + 12);
    x = 16'h2222;
    run(2 * FRAME - 12);

    // reduced brightness
    bright = 4'd3;
    run(2 * FRAME);

    // blinking digit 0
    bright = 4'd15; blink_mask = 4'b0001;
    run(5 * FRAME);

    // randomized traffic
    for (int k = 0; k < 12 * FRAME; k++) begin
      rnd_inputs();
      step();
    end

    // reset mid-slot: outputs go dark without waiting for a clock edge
    x = 16'hABCD; dp_in = 4'hF; blank = '0; blink_mask = '0; lz_en = 1'b0; bright = 4'd15;
    run(FRAME + 3);
    clr_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk_reset_outputs("rst_hold");
    end
    clr_n = 1'b1;
    model_reset();
    run(FRAME);
    for (int k = 0; k < 3 * FRAME; k++) begin
      rnd_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
